// File: rtl/servo_pwm_gen_if.sv
// rtl/servo_pwm_gen_if.sv - duty handshake between the PID controller and the servo PWM generator
interface servo_pwm_gen_if;
    logic [16:0] duty_in;
    logic        duty_valid;
    logic        duty_ready;

    modport master (output duty_in, output duty_valid, input duty_ready);
    modport slave  (input duty_in, input duty_valid, output duty_ready);
endinterface

// File: rtl/servo_pwm_gen.sv
// rtl/servo_pwm_gen.sv - fixed-period servo PWM with clamped, double-buffered duty
// Optional per-period slew limiting is enabled by defining SERVO_PWM_SLEW_EN.
module servo_pwm_gen #(
    parameter int PERIOD       = 1000000,
    parameter int MIN_DUTY     = 50000,
    parameter int MAX_DUTY     = 100000,
    parameter int DEFAULT_DUTY = 75000,
    parameter int SLEW_STEP    = 5000
) (
    input  logic              clk,
    input  logic              rst,
    servo_pwm_gen_if.slave    duty_if,
    output logic              pwm_out,
    output logic              period_start,
    output logic [16:0]       duty_active,
    output logic              clamp_hit
);
    localparam int CNT_W = $clog2(PERIOD);
    localparam int CMP_W = (CNT_W > 17) ? CNT_W : 17;

    if (SLEW_STEP <= 0 || MIN_DUTY > MAX_DUTY) begin : g_bad_cfg
        $error("servo_pwm_gen: invalid duty range or slew step");
    end

    logic [CNT_W-1:0] r_cnt;
    logic [16:0]      r_target;
    logic             r_pending;
    logic [16:0]      r_duty_active;
    logic             r_pwm;
    logic             r_period_start;
    logic             r_clamp_hit;

    logic [CNT_W-1:0] w_cnt_next;
    logic             w_boundary;
    logic             w_accept;
    logic             w_below;
    logic             w_above;
    logic [16:0]      w_clamped;
    logic [16:0]      w_slewed;
    logic [16:0]      w_duty_next;
    logic             w_pending_next;

    assign w_boundary = (r_cnt == CNT_W'(PERIOD - 1));
    assign w_cnt_next = w_boundary ? '0 : r_cnt + CNT_W'(1);
    assign w_accept   = duty_if.duty_valid && !r_pending;

    assign w_below   = (duty_if.duty_in < 17'(MIN_DUTY));
    assign w_above   = (duty_if.duty_in > 17'(MAX_DUTY));
    assign w_clamped = w_below ? 17'(MIN_DUTY) : (w_above ? 17'(MAX_DUTY) : duty_if.duty_in);

`ifdef SERVO_PWM_SLEW_EN
    logic        w_up;
    logic [16:0] w_diff;
    logic [16:0] w_step;
    assign w_up     = (r_target >= r_duty_active);
    assign w_diff   = w_up ? (r_target - r_duty_active) : (r_duty_active - r_target);
    assign w_step   = (w_diff < 17'(SLEW_STEP)) ? w_diff : 17'(SLEW_STEP);
    assign w_slewed = w_up ? (r_duty_active + w_step) : (r_duty_active - w_step);
`else
    assign w_slewed = r_target;
`endif

    // Boundary load sees pre-edge pending/target; an accept on that same edge waits a period.
    always_comb begin
        w_duty_next    = r_duty_active;
        w_pending_next = r_pending;
        if (w_boundary && r_pending) begin
            w_duty_next = w_slewed;
            if (w_slewed == r_target) begin
                w_pending_next = 1'b0;
            end
        end
        if (w_accept) begin
            w_pending_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt          <= CNT_W'(PERIOD - 1);
            r_target       <= 17'(DEFAULT_DUTY);
            r_pending      <= 1'b0;
            r_duty_active  <= 17'(DEFAULT_DUTY);
            r_pwm          <= 1'b0;
            r_period_start <= 1'b0;
            r_clamp_hit    <= 1'b0;
        end else begin
            r_cnt          <= w_cnt_next;
            r_pending      <= w_pending_next;
            r_duty_active  <= w_duty_next;
            r_pwm          <= (CMP_W'(w_cnt_next) < CMP_W'(w_duty_next));
            r_period_start <= (w_cnt_next == '0);
            r_clamp_hit    <= w_accept && (w_below || w_above);
            if (w_accept) begin
                r_target <= w_clamped;
            end
        end
    end

    assign duty_if.duty_ready = !r_pending;
    assign pwm_out            = r_pwm;
    assign period_start       = r_period_start;
    assign duty_active        = r_duty_active;
    assign clamp_hit          = r_clamp_hit;
endmodule

// File: tb/tb_servo_pwm_gen.sv
// tb/tb_servo_pwm_gen.sv - scoreboard bench for servo_pwm_gen with duties scaled down by 1000
module tb_servo_pwm_gen;
    localparam int P    = 200;
    localparam int MIN  = 50;
    localparam int MAX  = 100;
    localparam int DEF  = 75;
    localparam int SLEW = 5;

    typedef struct {int q; int val;} app_t;
    typedef struct {int t; int hit;} clamp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pwm_out;
    logic        period_start;
    logic [16:0] duty_active;
    logic        clamp_hit;

    servo_pwm_gen_if dif();

    servo_pwm_gen #(
        .PERIOD(P), .MIN_DUTY(MIN), .MAX_DUTY(MAX), .DEFAULT_DUTY(DEF), .SLEW_STEP(SLEW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .duty_if(dif),
        .pwm_out(pwm_out),
        .period_start(period_start),
        .duty_active(duty_active),
        .clamp_hit(clamp_hit)
    );

    always #5 clk = ~clk;

    int     errors = 0;
    int     checks = 0;
    int     t = -1;
    bit     rst_q = 1'b1;
    app_t   app_q[$];
    clamp_t clamp_q[$];

    int exp_cur = DEF;
    int tgt = DEF;
    bit moving = 1'b0;
    int hi = 0;
    int pos;
    int k;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            if (errors < 40)
                $display("FAIL %s: got %0d expected %0d at t=%0d", name, act, req, t);
        end
    endtask

    // t is the cycle index since reset release; cycle 0 is the first cnt==0 cycle
    always @(posedge clk) begin
        rst_q = rst;
        if (rst) t = -1;
        else     t = t + 1;
    end

    always @(negedge clk) begin
        if (rst_q) begin
            app_q.delete();
            clamp_q.delete();
            exp_cur = DEF;
            tgt = DEF;
            moving = 1'b0;
            hi = 0;
            check("rst_pwm_out", pwm_out, 0);
            check("rst_period_start", period_start, 0);
            check("rst_clamp_hit", clamp_hit, 0);
            check("rst_duty_ready", dif.duty_ready, 1);
            check("rst_duty_active", duty_active, DEF);
        end else if (t >= 0) begin
            pos = t % P;
            k = t / P;
            if (pos == 0) begin
                if (k > 0) check("high_cycles", hi, exp_cur);
                hi = 0;
                if (app_q.size() > 0 && app_q[0].q == k) begin
                    tgt = app_q[0].val;
                    moving = 1'b1;
                    void'(app_q.pop_front());
                end
                if (moving) begin
`ifdef SERVO_PWM_SLEW_EN
                    if (tgt > exp_cur) exp_cur += (tgt - exp_cur < SLEW) ? tgt - exp_cur : SLEW;
                    else               exp_cur -= (exp_cur - tgt < SLEW) ? exp_cur - tgt : SLEW;
`else
                    exp_cur = tgt;
`endif
                    if (exp_cur == tgt) moving = 1'b0;
                end
                check("ready_at_start", dif.duty_ready, (!moving && app_q.size() == 0) ? 1 : 0);
            end
            if (pwm_out) hi++;
            check("period_start", period_start, (pos == 0) ? 1 : 0);
            check("pwm_out", pwm_out, (pos < exp_cur) ? 1 : 0);
            check("duty_active", duty_active, exp_cur);
            if (clamp_q.size() > 0 && clamp_q[0].t == t) begin
                check("clamp_hit", clamp_hit, clamp_q[0].hit);
                void'(clamp_q.pop_front());
            end else if (clamp_hit) begin
                check("clamp_hit_spurious", 1, 0);
            end
        end
    end

    task automatic issue(input int v, input int at);
        int n = 0;
        int cv;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(t >= 0 && (t % P) == at && dif.duty_ready) && n < 12 * P);
        if (n >= 12 * P) begin
            check("issue_timeout", 0, 1);
            return;
        end
        cv = (v < MIN) ? MIN : ((v > MAX) ? MAX : v);
        dif.duty_in = 17'(v);
        dif.duty_valid = 1'b1;
        app_q.push_back('{q: (at == P - 1) ? t / P + 2 : t / P + 1, val: cv});
        clamp_q.push_back('{t: t + 1, hit: (cv != v) ? 1 : 0});
        @(posedge clk); #1;
        dif.duty_valid = 1'b0;
        check("ready_low_after_accept", dif.duty_ready, 0);
    endtask

    initial begin
        int n;
        dif.duty_in = '0;
        dif.duty_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2 * P) @(posedge clk);
        #1;
        issue(60, P / 2);
        issue(120, 40);
        issue(10, 60);
        issue(80, 20);
        issue(90, P - 1);
        issue(75, 5);
        issue(100, 10);
        for (int i = 0; i < 6; i++) issue($urandom_range(0, 160), $urandom_range(0, P - 1));
        issue(90, 50);
        issue(60, 20);
        n = 0;
        while ((t % P) != 30 && n < 2 * P) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2 * P) check("reset_wait_timeout", 0, 1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (P + P / 2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end
endmodule
